// File: rtl/sine_phase_reader.sv
// Sine phase reader: turns an up-counting phase stream into sine samples through two
// half-wave tables, and measures the stream period as accepted words between phase wraps.
module sine_phase_reader #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   phase,
    input  logic                    phase_valid,
    output logic                    phase_ready,
    output logic [DATA_WIDTH-1:0]   sample,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid
);

    localparam int unsigned ROM_DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned HALF      = ROM_DEPTH / 2;
    localparam int unsigned QUARTER   = ROM_DEPTH / 4;
    localparam int          FRAC      = 60;
    localparam logic [63:0] PI_Q60    = 64'h3243_F6A8_885A_308D;
    localparam logic [DATA_WIDTH-1:0] FULL_SCALE = DATA_WIDTH'(1) << (DATA_WIDTH - 2);

    // Table word for entry idx: trunc(sin(pi*idx/HALF) * 2^(DATA_WIDTH-2)), evaluated at
    // elaboration with a Q60 Taylor series on the first quadrant and folded by symmetry.
    function automatic logic [DATA_WIDTH-1:0] sine_entry(input int unsigned idx);
        logic [127:0]          x;
        logic [127:0]          x2;
        logic [127:0]          term;
        logic [127:0]          pos_sum;
        logic [127:0]          neg_sum;
        logic [DATA_WIDTH-1:0] mag;
        int unsigned           h;
        int unsigned           k;
        h = idx % HALF;
        k = (h <= QUARTER) ? h : HALF - h;
        if (k == QUARTER) begin
            mag = FULL_SCALE;
        end else begin
            x       = (128'(PI_Q60) * 128'(k)) >> (ADDR_WIDTH - 1);
            x2      = (x * x) >> FRAC;
            term    = x;
            pos_sum = x;
            neg_sum = '0;
            for (int n = 1; n <= 12; n++) begin
                term = ((term * x2) >> FRAC) / 128'((2 * n) * (2 * n + 1));
                if (n % 2 == 1) neg_sum = neg_sum + term;
                else            pos_sum = pos_sum + term;
            end
            mag = DATA_WIDTH'((pos_sum - neg_sum) >> (FRAC - (DATA_WIDTH - 2)));
        end
        return (idx >= HALF) ? -mag : mag;
    endfunction

    function automatic logic [PERIOD_WIDTH-1:0] sat_inc(input logic [PERIOD_WIDTH-1:0] value);
        return (value == {PERIOD_WIDTH{1'b1}}) ? value : value + PERIOD_WIDTH'(1);
    endfunction

    // table1 covers phase MSB=0 (positive half-wave), table2 covers MSB=1.
    logic [DATA_WIDTH-1:0] table1 [HALF];
    logic [DATA_WIDTH-1:0] table2 [HALF];

    for (genvar g = 0; g < HALF; g++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] WORD1 = sine_entry(g);
        localparam logic [DATA_WIDTH-1:0] WORD2 = sine_entry(g + HALF);
        assign table1[g] = WORD1;
        assign table2[g] = WORD2;
    end

    logic advance;
    logic accept;

    assign advance     = !sample_valid || sample_ready;
    assign phase_ready = advance;
    assign accept      = phase_valid && advance;

    // ---- S1: register phase word ----
    logic [ADDR_WIDTH-1:0] phase_p1;
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] word_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= phase_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            phase_p1 <= phase;
        end
    end

    assign word_p1 = phase_p1[ADDR_WIDTH-1] ? table2[phase_p1[ADDR_WIDTH-2:0]]
                                            : table1[phase_p1[ADDR_WIDTH-2:0]];

    // ---- S2: register table word into the output sample ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_valid <= 1'b0;
            sample       <= '0;
        end else if (advance) begin
            sample_valid <= vld_p1;
            if (vld_p1) begin
                sample <= word_p1;
            end
        end
    end

    // Wrap detector runs on accepted words only, so output stalls never disturb it.
    logic                    prev_msb;
    logic                    armed;
    logic                    wrap;
    logic [PERIOD_WIDTH-1:0] count;

    assign wrap = accept && prev_msb && !phase[ADDR_WIDTH-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_msb     <= 1'b0;
            armed        <= 1'b0;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (accept) begin
                prev_msb <= phase[ADDR_WIDTH-1];
                if (wrap) begin
                    count <= PERIOD_WIDTH'(1);
                    armed <= 1'b1;
                    if (armed) begin
                        period       <= count;
                        period_valid <= 1'b1;
                    end
                end else begin
                    count <= sat_inc(count);
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_phase_reader.sv
// Bench for sine_phase_reader: scoreboarded samples and wrap periods on a 16-bit and a
// 4-bit period instance driven by the same phase stream.
module tb_sine_phase_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  phase;
    logic        phase_valid;
    logic        phase_ready;
    logic        phase_ready4;
    logic [31:0] sample;
    logic [31:0] sample4;
    logic        sample_valid;
    logic        sample_valid4;
    logic        sample_ready;
    logic [15:0] period;
    logic [3:0]  period4;
    logic        period_valid;
    logic        period_valid4;

    always #5 clk = ~clk;

    sine_phase_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .PERIOD_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .phase(phase), .phase_valid(phase_valid),
        .phase_ready(phase_ready), .sample(sample), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .period(period), .period_valid(period_valid)
    );

    sine_phase_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .PERIOD_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .phase(phase), .phase_valid(phase_valid),
        .phase_ready(phase_ready4), .sample(sample4), .sample_valid(sample_valid4),
        .sample_ready(sample_ready), .period(period4), .period_valid(period_valid4)
    );

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;
    logic        per_due;
    int          per_exp;
    int          want_period;
    logic        hold_chk;
    logic [31:0] held;
    int          n_samples;
    int          n_pulses;
    int          last_period;
    logic        saw_stall;
    logic        m_prev_msb;
    logic        m_armed;
    int          m_idx;
    int          m_last_wrap;
    int          stall_left;
    int          cur;
    int          n0;
    int          p0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_sample(input logic [7:0] p);
        real a;
        int  v;
        a = $sin(3.14159265358979323846 * real'(p) / 128.0) * 1073741824.0;
        v = $rtoi(a);
        return v;
    endfunction

    function automatic void flush();
        exp_q.delete();
        per_due     = 1'b0;
        hold_chk    = 1'b0;
        m_prev_msb  = 1'b0;
        m_armed     = 1'b0;
        m_idx       = 0;
        m_last_wrap = 0;
    endfunction

    // Checks what the last edge produced, then predicts the transfer at the next edge.
    always @(negedge clk) begin
        check("phase_ready", 64'(phase_ready), 64'(!sample_valid || sample_ready));
        check("dut4_mirror", 64'({phase_ready4, sample_valid4, sample4}),
              64'({phase_ready, sample_valid, sample}));
        if (hold_chk) check("stall_hold", 64'({sample_valid, sample}), 64'({1'b1, held}));
        hold_chk = sample_valid && !sample_ready;
        held     = sample;
        if (!phase_ready) saw_stall = 1'b1;
        if (sample_valid && sample_ready) begin
            n_samples++;
            check("sample_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                exp_word = exp_q.pop_front();
                check("sample", 64'(sample), 64'(exp_word));
            end
        end
        check("period_valid", 64'(period_valid), 64'(per_due));
        check("period_valid4", 64'(period_valid4), 64'(per_due));
        if (period_valid) last_period = int'(period);
        if (per_due && period_valid) begin
            n_pulses++;
            check("period", 64'(period), 64'(per_exp));
            check("period4", 64'(period4), 64'((per_exp > 15) ? 15 : per_exp));
            if (want_period != 0) begin
                check("period_const", 64'(period), 64'(want_period));
                check("period4_const", 64'(period4), 64'((want_period > 15) ? 15 : want_period));
            end
        end
        per_due = 1'b0;
        if (phase_valid && phase_ready && reset) begin
            exp_q.push_back(exp_sample(phase));
            m_idx++;
            if (m_prev_msb && !phase[7]) begin
                if (m_armed) begin
                    per_due = 1'b1;
                    per_exp = m_idx - m_last_wrap;
                end
                m_armed     = 1'b1;
                m_last_wrap = m_idx;
            end
            m_prev_msb = phase[7];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            stall_left--;
            sample_ready = 1'b0;
        end else begin
            sample_ready = 1'b1;
        end
        #1;
    endtask

    task automatic send(input logic [7:0] p);
        int   guard;
        logic acc;
        guard       = 0;
        acc         = 1'b0;
        phase       = p;
        phase_valid = 1'b1;
        while (!acc && guard < 64) begin
            acc = phase_ready;
            step();
            guard++;
        end
        check("send_accepted", 64'(acc), 64'(1));
    endtask

    task automatic idle(input int n);
        phase_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic run(input int incr, input int n);
        for (int i = 0; i < n; i++) begin
            send(8'(cur));
            cur = (cur + incr) % 256;
        end
    endtask

    task automatic hard_reset();
        phase_valid = 1'b0;
        reset       = 1'b0;
        #1;
        check("rst_sample", 64'(sample), 64'(0));
        check("rst_sample_valid", 64'(sample_valid), 64'(0));
        check("rst_period", 64'(period), 64'(0));
        check("rst_period4", 64'(period4), 64'(0));
        check("rst_period_valid", 64'(period_valid), 64'(0));
        check("rst_phase_ready", 64'(phase_ready), 64'(1));
        flush();
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; n_samples = 0; n_pulses = 0; last_period = 0;
        want_period = 0; saw_stall = 1'b0; stall_left = 0; cur = 0; per_exp = 0;
        held = '0; exp_word = '0;
        reset = 1'b1; phase = '0; phase_valid = 1'b0; sample_ready = 1'b1;
        flush();
        #1;
        hard_reset();

        send(8'd0);
        check("lat_bubble", 64'(sample_valid), 64'(0));
        send(8'd64);
        check("lat_s0", 64'({sample_valid, sample}), 64'({1'b1, 32'h0000_0000}));
        send(8'd128);
        check("lat_s64", 64'({sample_valid, sample}), 64'({1'b1, 32'h4000_0000}));
        send(8'd192);
        check("lat_s128", 64'({sample_valid, sample}), 64'({1'b1, 32'h0000_0000}));
        idle(1);
        check("lat_s192", 64'({sample_valid, sample}), 64'({1'b1, 32'hC000_0000}));
        idle(2);

        send(8'd32);  idle(1);
        send(8'd96);  idle(2);
        send(8'd160); idle(3);

        n0 = n_samples;
        saw_stall = 1'b0;
        stall_left = 5;
        for (int i = 0; i < 64; i++) send(8'(200 + i));
        idle(8);
        check("stall_seen", 64'(saw_stall), 64'(1));
        check("stall_count", 64'(n_samples - n0), 64'(64));

        hard_reset();
        want_period = 256;
        p0 = n_pulses;
        cur = 0;
        run(1, 1025);
        idle(3);
        check("incr1_pulses", 64'(n_pulses - p0), 64'(3));

        want_period = 128;
        p0 = n_pulses;
        cur = 2;
        run(2, 384);
        idle(2);
        check("incr2_pulses", 64'(n_pulses - p0), 64'(3));

        want_period = 0;
        p0 = n_pulses;
        run(2, 50);
        run(3, 53);
        idle(1);
        check("mixed_pulses", 64'(n_pulses - p0), 64'(1));
        check("mixed_period", 64'(last_period), 64'(103));
        run(3, 255);
        idle(2);

        idle(2);
        send(8'd10);
        send(8'd11);
        check("inflight_valid", 64'(sample_valid), 64'(1));
        hard_reset();
        idle(4);
        check("no_stale", 64'(sample_valid), 64'(0));
        want_period = 256;
        p0 = n_pulses;
        cur = 200;
        run(1, 313);
        idle(3);
        check("rearm_pulses", 64'(n_pulses - p0), 64'(1));

        idle(4);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_phase_reader.md
Name: sine_phase_reader

Overview:
- Consumer end of the phase-counter interface.
- Accepts the phase/address stream produced by the up/down phase counter and converts each phase to a sine sample through the generated half-wave tables.
  - table1.vh holds phase MSB=0.
  - table2.vh holds phase MSB=1.
- Also recovers the stream's frequency by measuring the number of accepted samples between successive phase wraps.
- Sits between the phase counter and the downstream DAC/sample sink.

Parameters:
ADDR_WIDTH, 8, phase width; ROM_DEPTH = 1<<ADDR_WIDTH, each table holds ROM_DEPTH/2 entries.
DATA_WIDTH, 32, sample width, two's complement, full scale ±2^(DATA_WIDTH-2).
PERIOD_WIDTH, 16, width of the measured-period output.

Ports:
clk  input  1  clock, all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
phase  input  ADDR_WIDTH  phase word from counter.
phase_valid  input  1  phase word valid.
phase_ready  output  1  block can accept a phase word this cycle.
sample  output  DATA_WIDTH  sine sample.
sample_valid  output  1  sample valid.
sample_ready  input  1  sink accepts sample.
period  output  PERIOD_WIDTH  accepted samples between the last two wraps.
period_valid  output  1  one-cycle pulse when period updates.

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - sample, sample_valid, period and period_valid are 0.
  - Pipeline valid bits are cleared.
  - Sample count is cleared.
  - The wrap detector is disarmed.
- Reset may assert mid-operation. In-flight samples are dropped and never emitted.
- Handshakes:
  - A transfer occurs on a rising edge with valid=1 and ready=1.
  - Input rule: phase and phase_valid hold until accepted.
  - Output rule: sample and sample_valid hold stable while sample_valid=1 and sample_ready=0.
- Pipeline: two stages.
  - S1 registers phase and selects the table by phase[ADDR_WIDTH-1].
  - S2 registers the table word, indexed by phase[ADDR_WIDTH-2:0], into sample.
  - Latency is 2 cycles from acceptance to sample_valid when there is no stall.
- Stall and throughput:
  - advance = !sample_valid || sample_ready.
  - phase_ready = advance, combinational from sample_valid and sample_ready only.
  - Sustained throughput is 1 sample per clock with sample_ready held 1.
  - Bubbles (phase_valid=0) propagate as sample_valid=0 and do not stall the pipeline.
- Table mapping: table entry i (0 ≤ i < ROM_DEPTH) = trunc(sin(π·i/(ROM_DEPTH/2))·2^(DATA_WIDTH-2)), stored as a DATA_WIDTH-bit pattern.
- Wrap detector, updated only on accepted phase words:
  - Wrap = previous accepted MSB=1 and current MSB=0. This holds for up-counting streams.
  - count increments by 1 per accepted word and saturates at 2^PERIOD_WIDTH-1.
  - On a wrap, the current word starts a new count: count:=1.
  - The first wrap after reset only arms the detector. There is no period_valid.
  - Each later wrap sets period:=count (the prior value) and pulses period_valid for one cycle.
  - period holds until the next update.
- Phase stream changes:
  - An MSB transition 0→1 is not a wrap.
  - Down-counting streams therefore measure wraps at the 0→… boundary incorrectly by design; only up-count is specified.
  - A preload that jumps the phase across the MSB boundary is treated like any word: a 1→0 MSB jump counts as a wrap.
- Simultaneity: an output stall does not affect period; period_valid is tied to input acceptance, not output.

Test Plan:
- ADDR_WIDTH=8. Feed phases 0, 64, 128, 192 back-to-back with sample_ready=1 -> samples arrive 2 cycles after acceptance, in order:
  - 0x00000000
  - 0x40000000
  - 0x00000000 (truncated ~0)
  - 0xC0000000
- Hold sample_ready=0 for 5 cycles with phase_valid=1 -> phase_ready drops once the pipeline fills. sample stays stable. No sample is lost or duplicated; 64 sequential phases yield 64 samples, checked against the table formula.
- Counter with incr=1 running >3 wraps -> no period_valid at the first wrap; each later wrap gives period=256 with a 1-cycle pulse.
- incr=2, then incr=3 -> period=128. Then the repeating pattern 85,85,86 (the incr=3 pattern). After the incr change, the first reported period reflects the mixed interval.
- Assert reset low mid-stream with 2 words in flight -> outputs go 0 immediately (asynchronously). After release:
  - No stale sample appears.
  - The first wrap re-arms without a period_valid.
- PERIOD_WIDTH=4, incr=1 -> count saturates; period=15 reported at each wrap after arming.
